alu_share_ctrl: RTL and testbench

//  Shares one combinational alu instance (op/a/b in, result/status out) between two requesters.

---
 rtl/alu_share_ctrl.sv | 163 ++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: arbitration, operand issue, result capture and response hold.
// Optional: define ALU_SHARE_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module alu_share_ctrl #(
  parameter int W        = 8,
  parameter int OP_W     = 2,
  parameter int STATUS_W = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OP_W-1:0]     req0_op,
  input  logic [W-1:0]        req0_a,
  input  logic [W-1:0]        req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OP_W-1:0]     req1_op,
  input  logic [W-1:0]        req1_a,
  input  logic [W-1:0]        req1_b,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [W-1:0]        rsp_result,
  output logic [STATUS_W-1:0] rsp_status,
  output logic [OP_W-1:0]     alu_op,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  input  logic [W-1:0]        alu_result,
  input  logic [STATUS_W-1:0] alu_status,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [W-1:0]        alu_a_q, alu_a_d;
  logic [W-1:0]        alu_b_q, alu_b_d;
  logic [W-1:0]        rsp_result_q, rsp_result_d;
  logic [STATUS_W-1:0] rsp_status_q, rsp_status_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic                busy_q, busy_d;
  logic                grant_s;
  logic                accept_s;

  // Arbitration: a lone requester always wins; contention is broken by policy.
  always_comb begin
    grant_s  = 1'b0;
    accept_s = (state_q == S_IDLE) && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      grant_s = 1'b0;
`else
      grant_s = ~last_grant_q;
`endif
    end else begin
      grant_s = req1_valid;
    end
    req0_ready = accept_s && !grant_s;
    req1_ready = accept_s && grant_s;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d      = S_ISSUE;
          owner_d      = grant_s;
          last_grant_d = grant_s;
          alu_op_d     = grant_s ? req1_op : req0_op;
          alu_a_d      = grant_s ? req1_a  : req0_a;
          alu_b_d      = grant_s ? req1_b  : req0_b;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d      = S_RESP;
        rsp_result_d = alu_result;
        rsp_status_d = alu_status;
        rsp0_valid_d = !owner_q;
        rsp1_valid_d = owner_q;
      end
      S_RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_d      = S_IDLE;
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d      = S_IDLE;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; last_grant resets to 1 so requester 0 wins first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_op_q     <= {OP_W{1'b0}};
      alu_a_q      <= {W{1'b0}};
      alu_b_q      <= {W{1'b0}};
      rsp_result_q <= {W{1'b0}};
      rsp_status_q <= {STATUS_W{1'b0}};
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_result = rsp_result_q;
  assign rsp_status = rsp_status_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: directed cases, reset cases and randomized two-requester traffic.
module tb_alu_share_ctrl;
  localparam int W = 8;
  localparam int OP_W = 2;
  localparam int SW = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 1'b0, req0_ready;
  logic [OP_W-1:0] req0_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0;
  logic req1_valid = 1'b0, req1_ready;
  logic [OP_W-1:0] req1_op = '0;
  logic [W-1:0] req1_a = '0, req1_b = '0;
  logic rsp0_valid, rsp1_valid;
  logic rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [W-1:0] rsp_result;
  logic [SW-1:0] rsp_status;
  logic [OP_W-1:0] alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [SW-1:0] alu_status;
  logic busy;

  always #5 clk = ~clk;

  alu_share_ctrl #(.W(W), .OP_W(OP_W), .STATUS_W(SW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_status(rsp_status),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_status(alu_status),
    .busy(busy)
  );

  // Bench ALU: add (carry), sub (no-borrow), xor (zero), and (status 0).
  function automatic logic [8:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic st;
    s = 9'd0;
    case (op)
      2'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; st = s[8]; end
      2'd1: begin r = a - b; st = (a >= b); end
      2'd2: begin r = a ^ b; st = (r == 8'h00); end
      default: begin r = a & b; st = 1'b0; end
    endcase
    return {st, r};
  endfunction

  assign {alu_status, alu_result} = alu_f(alu_op, alu_a, alu_b);

  typedef struct packed {
    logic        owner;
    logic [7:0]  res;
    logic        st;
    logic [31:0] acc;
  } exp_t;

  exp_t sb_q[$];
  logic obs_owner[$];
  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int unsigned m_idle_at = 0;
  int unsigned last_acc = 0;
  logic m_last = 1'b1;
  logic seen = 1'b0;
  logic pend_v[2];
  logic [1:0] pend_op[2];
  logic [7:0] pend_a[2], pend_b[2], pend_res[2];
  logic pend_st[2];
  logic rr0 = 1'b1, rr1 = 1'b1;
  logic rand_rr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d bound expired", name, cyc);
  endtask

  task automatic set_req(input int n, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic st);
    pend_v[n] = 1'b1; pend_op[n] = op; pend_a[n] = a; pend_b[n] = b;
    pend_res[n] = res; pend_st[n] = st;
  endtask

  task automatic set_rand(input int n);
    logic [1:0] op;
    logic [7:0] a, b;
    logic [8:0] r;
    op = 2'($urandom_range(0, 3));
    a = 8'($urandom);
    b = 8'($urandom);
    r = alu_f(op, a, b);
    set_req(n, op, a, b, r[7:0], r[8]);
  endtask

  // One cycle: drive at negedge, then check arbitration against the model.
  task automatic step();
    logic idle, g, e0, e1;
    @(negedge clk);
    req0_valid = pend_v[0]; req0_op = pend_op[0]; req0_a = pend_a[0]; req0_b = pend_b[0];
    req1_valid = pend_v[1]; req1_op = pend_op[1]; req1_a = pend_a[1]; req1_b = pend_b[1];
    if (rand_rr) begin
      rr0 = ($urandom_range(0, 2) != 0);
      rr1 = ($urandom_range(0, 2) != 0);
    end
    rsp0_ready = rr0; rsp1_ready = rr1;
    #1;
    idle = (cyc >= m_idle_at);
    g = 1'b0; e0 = 1'b0; e1 = 1'b0;
    if (idle && (pend_v[0] || pend_v[1])) begin
      if (pend_v[0] && pend_v[1]) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
        g = 1'b0;
`else
        g = ~m_last;
`endif
      end else begin
        g = pend_v[1];
      end
      e0 = !g; e1 = g;
    end
    chk("req_ready", {req1_ready, req0_ready}, {e1, e0});
    chk("busy", busy, !idle);
    if (e0 || e1) begin
      sb_q.push_back('{owner: g, res: pend_res[g], st: pend_st[g], acc: cyc});
      m_last = g;
      m_idle_at = 32'hFFFF_FFFF;
      last_acc = cyc;
      pend_v[g] = 1'b0;
    end
  endtask

  task automatic issue(input int n, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] res, input logic st);
    int t;
    set_req(n, op, a, b, res, st);
    t = 0;
    while (pend_v[n] && t < 40) begin step(); t++; end
    if (pend_v[n]) fail_now("accept_timeout");
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((pend_v[0] || pend_v[1] || sb_q.size() != 0 || cyc < m_idle_at) && t < 300) begin
      step(); t++;
    end
    if (pend_v[0] || pend_v[1] || sb_q.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_result", {rsp_status, rsp_result}, 32'd0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 32'd0);
    sb_q.delete();
    seen = 1'b0;
    m_last = 1'b1;
    m_idle_at = 0;
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: compare every presented response against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && (rsp0_valid || rsp1_valid)) begin
        if (sb_q.size() == 0) begin
          fail_now("spurious_rsp");
        end else begin
          e = sb_q[0];
          chk("rsp_channel", {rsp1_valid, rsp0_valid}, e.owner ? 32'd2 : 32'd1);
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_status", rsp_status, e.st);
          if (!seen) begin
            chk("latency", cyc - e.acc, 32'd3);
            seen = 1'b1;
          end
          if (e.owner ? rsp1_ready : rsp0_ready) begin
            void'(sb_q.pop_front());
            obs_owner.push_back(rsp1_valid);
            seen = 1'b0;
            m_idle_at = cyc + 1;
          end
        end
      end
    end
  end

  initial begin
    logic exp_own[4];
    int unsigned c;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    do_reset();

    // Single requests with hand-computed results.
    issue(0, 2'd0, 8'hF0, 8'h20, 8'h10, 1'b1);
    wait_drain();
    issue(1, 2'd1, 8'h05, 8'h03, 8'h02, 1'b1);
    wait_drain();
    issue(1, 2'd1, 8'h03, 8'h05, 8'hFE, 1'b0);
    wait_drain();

    // Contention from reset with both requests held.
    do_reset();
    obs_owner.delete();
    for (int i = 0; i < 20; i++) begin
      if (!pend_v[0]) set_req(0, 2'd0, 8'h11, 8'h22, 8'h33, 1'b0);
      if (!pend_v[1]) set_req(1, 2'd3, 8'h0F, 8'h3C, 8'h0C, 1'b0);
      step();
    end
    wait_drain();
`ifdef ALU_SHARE_FIXED_PRIO_EN
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    if (obs_owner.size() < 4) fail_now("grant_count");
    else for (int i = 0; i < 4; i++) chk("grant_order", obs_owner[i], exp_own[i]);

    // Backpressure: response held five cycles while req1 waits.
    rr0 = 1'b0;
    issue(0, 2'd2, 8'h10, 8'h10, 8'h00, 1'b1);
    c = last_acc;
    set_req(1, 2'd0, 8'h01, 8'h02, 8'h03, 1'b0);
    while (cyc < c + 7) step();
    rr0 = 1'b1;
    wait_drain();

    // Reset during ISSUE, then during RESP.
    issue(0, 2'd0, 8'h12, 8'h34, 8'h46, 1'b0);
    step();
    do_reset();
    repeat (6) step();
    rr1 = 1'b0;
    issue(1, 2'd1, 8'h40, 8'h01, 8'h3F, 1'b1);
    c = last_acc;
    while (cyc < c + 3) step();
    do_reset();
    rr1 = 1'b1;
    repeat (6) step();
    issue(1, 2'd0, 8'hFF, 8'h01, 8'h00, 1'b1);
    wait_drain();

    // Randomized traffic with random response backpressure.
    rand_rr = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      for (int n = 0; n < 2; n++)
        if (!pend_v[n] && $urandom_range(0, 2) != 0) set_rand(n);
      step();
    end
    wait_drain();
    rand_rr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
